psum_ofifo: RTL and testbench

South-side output collector for the systolic array. It captures the per-column partial sums (`out_s`) that a MAC row emits, using that row's staggered per-column `valid` strobes as write enables. It realigns the skewed column outputs into complete rows and presents them, first-word-fall-through, to the downstream SRAM/accumulator writer under a simple read handshake.

---
 rtl/psum_ofifo_pkg.sv | 15 +
 rtl/psum_col_fifo.sv | 59 +++++
 rtl/psum_ofifo.sv | 63 ++++++
 tb/tb_psum_ofifo.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/psum_ofifo_pkg.sv
// psum_ofifo_pkg: shared helpers for the systolic-array output collector.
// Pointer width and per-column slice offsets used by top and column FIFOs.
package psum_ofifo_pkg;

    // Pointer width: address bits plus one wrap bit.
    function automatic int ptr_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    // LSB offset of column i inside a packed row.
    function automatic int col_lsb(input int i, input int bw);
        return bw * i;
    endfunction

endpackage

// File: rtl/psum_col_fifo.sv
// psum_col_fifo: one column FWFT FIFO with wrap-bit pointers.
// Ports: clk, reset (async low), wr/din push, rd pop, dout head, empty, full, drop.
module psum_col_fifo
    import psum_ofifo_pkg::*;
#(
    parameter int BW    = 16,
    parameter int DEPTH = 64
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [BW-1:0] din,
    input  logic          rd,
    output logic [BW-1:0] dout,
    output logic          empty,
    output logic          full,
    output logic          drop
);

    localparam int PW = ptr_w(DEPTH);
    localparam int AW = PW - 1;

    logic [PW-1:0] wptr_q, wptr_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic [BW-1:0] mem_q [DEPTH];
    logic          push;

    assign empty = (wptr_q == rptr_q);
    assign full  = (wptr_q[AW-1:0] == rptr_q[AW-1:0])
                && (wptr_q[AW] != rptr_q[AW]);

    // A pop in the same cycle frees the slot a full push needs.
    // rd arrives already qualified by the row being complete.
    assign push = wr && (!full || rd);
    assign drop = wr && !push;

    assign wptr_d = wptr_q + PW'(push);
    assign rptr_d = rptr_q + PW'(rd);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage is not reset; zeroed pointers hide stale entries.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q[AW-1:0]] <= din;
        end
    end

    assign dout = mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/psum_ofifo.sv
// psum_ofifo: realigns skewed per-column psums into rows, FWFT read side.
// Ports: clk, reset, in/wr push, rd pop, out row, o_valid/o_full/o_ready/o_overflow.
module psum_ofifo
    import psum_ofifo_pkg::*;
#(
    parameter int psum_bw = 16,
    parameter int col     = 8,
    parameter int depth   = 64
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [psum_bw*col-1:0] in,
    input  logic [col-1:0]         wr,
    input  logic                   rd,
    output logic [psum_bw*col-1:0] out,
    output logic                   o_valid,
    output logic                   o_full,
    output logic                   o_ready,
    output logic                   o_overflow
);

    logic [col-1:0] empty;
    logic [col-1:0] full;
    logic [col-1:0] drop;
    logic           pop;
    logic           ovf_q, ovf_d;

    for (genvar i = 0; i < col; i++) begin : g_col
        psum_col_fifo #(
            .BW    (psum_bw),
            .DEPTH (depth)
        ) u_fifo (
            .clk   (clk),
            .reset (reset),
            .wr    (wr[i]),
            .din   (in[col_lsb(i, psum_bw) +: psum_bw]),
            .rd    (pop),
            .dout  (out[col_lsb(i, psum_bw) +: psum_bw]),
            .empty (empty[i]),
            .full  (full[i]),
            .drop  (drop[i])
        );
    end

    // A row is complete only once the slowest column has arrived.
    assign o_valid = &(~empty);
    assign o_full  = |full;
    assign o_ready = !o_full;
    assign pop     = rd && o_valid;

    assign ovf_d = ovf_q | (|drop);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign o_overflow = ovf_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// tb_psum_ofifo: vectors, corner sequences and random traffic
// against a queue-based reference of the row collector.
module tb_psum_ofifo;

    localparam int BW = 16;
    localparam int NC = 8;
    localparam int DP = 4;
    localparam int W  = BW * NC;

    logic         clk;
    logic         reset;
    logic [W-1:0] in_s;
    logic [NC-1:0] wr_s;
    logic         rd_s;
    logic [W-1:0] out_s;
    logic         o_valid;
    logic         o_full;
    logic         o_ready;
    logic         o_overflow;

    int n_cmp = 0;
    int n_err = 0;

    logic [BW-1:0] mq [NC][$];
    logic          m_ovf;

    psum_ofifo #(
        .psum_bw (BW),
        .col     (NC),
        .depth   (DP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in         (in_s),
        .wr         (wr_s),
        .rd         (rd_s),
        .out        (out_s),
        .o_valid    (o_valid),
        .o_full     (o_full),
        .o_ready    (o_ready),
        .o_overflow (o_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [NC-1:0] wr;
        logic          rd;
        logic          ev;
        logic          ef;
        logic          eo;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic logic [W-1:0] mkrow(input logic [BW-1:0] b);
        logic [W-1:0] r;
        for (int i = 0; i < NC; i++) r[i*BW +: BW] = b + BW'(i);
        return r;
    endfunction

    function automatic logic m_valid();
        for (int i = 0; i < NC; i++)
            if (mq[i].size() == 0) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_full();
        for (int i = 0; i < NC; i++)
            if (mq[i].size() == DP) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [W-1:0] m_head();
        logic [W-1:0] r;
        r = '0;
        for (int i = 0; i < NC; i++)
            if (mq[i].size() > 0) r[i*BW +: BW] = mq[i][0];
        return r;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < NC; i++) mq[i].delete();
        m_ovf = 1'b0;
    endtask

    task automatic m_edge(input logic [NC-1:0] w, input logic [W-1:0] d,
                          input logic r);
        logic pop;
        int   sz;
        pop = r && m_valid();
        for (int i = 0; i < NC; i++) begin
            sz = mq[i].size();
            if (pop) void'(mq[i].pop_front());
            if (w[i]) begin
                if (sz < DP || pop) mq[i].push_back(d[i*BW +: BW]);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_all();
        logic v, f;
        v = m_valid();
        f = m_full();
        chk("valid", W'(o_valid), W'(v));
        chk("full", W'(o_full), W'(f));
        chk("ready", W'(o_ready), W'(!f));
        chk("overflow", W'(o_overflow), W'(m_ovf));
        if (v) chk("out", out_s, m_head());
    endtask

    task automatic step(input logic [NC-1:0] w, input logic [W-1:0] d,
                        input logic r);
        @(negedge clk);
        wr_s = w;
        in_s = d;
        rd_s = r;
        @(posedge clk);
        m_edge(w, d, r);
        #1;
        check_all();
    endtask

    task automatic async_rst();
        @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        chk("rst_valid", W'(o_valid), W'(0));
        chk("rst_full", W'(o_full), W'(0));
        chk("rst_ready", W'(o_ready), W'(1));
        chk("rst_ovf", W'(o_overflow), W'(0));
        m_clear();
        @(negedge clk);
        wr_s = '0;
        rd_s = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        logic [W-1:0] d;
        reset = 1'b0;
        wr_s  = '0;
        rd_s  = 1'b0;
        in_s  = '0;
        m_clear();

        // reset held with random traffic
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            wr_s = NC'($urandom);
            rd_s = 1'($urandom);
            in_s = {$urandom, $urandom, $urandom, $urandom};
            #1;
            chk("hold_valid", W'(o_valid), W'(0));
            chk("hold_full", W'(o_full), W'(0));
            chk("hold_ready", W'(o_ready), W'(1));
            chk("hold_ovf", W'(o_overflow), W'(0));
        end
        @(negedge clk);
        wr_s  = '0;
        rd_s  = 1'b0;
        reset = 1'b1;
        step('0, '0, 1'b1);
        chk("rd_empty", W'(o_valid), W'(0));

        // skewed fill vectors
        for (int i = 0; i < NC; i++)
            tbl[i] = '{wr: NC'(1) << i, rd: 1'b0,
                       ev: (i == NC - 1), ef: 1'b0, eo: 1'b0};
        tbl[8] = '{wr: '0, rd: 1'b1, ev: 1'b0, ef: 1'b0, eo: 1'b0};
        tbl[9] = '{wr: '0, rd: 1'b1, ev: 1'b0, ef: 1'b0, eo: 1'b0};
        for (int k = 0; k < 2; k++) step('0, '0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            step(tbl[k].wr, mkrow(16'h0100), tbl[k].rd);
            chk("tv_valid", W'(o_valid), W'(tbl[k].ev));
            chk("tv_full", W'(o_full), W'(tbl[k].ef));
            chk("tv_ovf", W'(o_overflow), W'(tbl[k].eo));
            if (tbl[k].ev) chk("tv_out", out_s, mkrow(16'h0100));
        end

        // full and overflow
        for (int r = 0; r < DP; r++)
            step('1, mkrow(16'h1000 + 16'(r * 16)), 1'b0);
        chk("full4", W'(o_full), W'(1));
        chk("ready4", W'(o_ready), W'(0));
        d = '0;
        d[BW-1:0] = 16'hDEAD;
        step(NC'(1), d, 1'b0);
        chk("ovf_set", W'(o_overflow), W'(1));
        for (int r = 0; r < DP; r++) begin
            chk("ovf_drain", out_s, mkrow(16'h1000 + 16'(r * 16)));
            step('0, '0, 1'b1);
        end
        chk("ovf_empty", W'(o_valid), W'(0));
        chk("ovf_sticky", W'(o_overflow), W'(1));
        async_rst();

        // push and pop together at full
        for (int r = 0; r < DP; r++)
            step('1, mkrow(16'h2000 + 16'(r * 16)), 1'b0);
        step('1, mkrow(16'h0A00), 1'b1);
        chk("pp_ovf", W'(o_overflow), W'(0));
        chk("pp_full", W'(o_full), W'(1));
        for (int r = 1; r < DP; r++) begin
            chk("pp_drain", out_s, mkrow(16'h2000 + 16'(r * 16)));
            step('0, '0, 1'b1);
        end
        chk("pp_last", out_s, mkrow(16'h0A00));
        step('0, '0, 1'b1);
        chk("pp_empty", W'(o_valid), W'(0));

        // wrap stress
        step('1, mkrow(16'h3000), 1'b0);
        for (int r = 1; r < 3 * DP; r++) begin
            chk("wrap_out", out_s, mkrow(16'h3000 + 16'((r - 1) * 16)));
            step('1, mkrow(16'h3000 + 16'(r * 16)), 1'b1);
            chk("wrap_ovf", W'(o_overflow), W'(0));
        end
        chk("wrap_tail", out_s, mkrow(16'h3000 + 16'((3 * DP - 1) * 16)));
        step('0, '0, 1'b1);

        // async reset mid-run
        step('1, mkrow(16'h4000), 1'b0);
        step('1, mkrow(16'h4010), 1'b0);
        chk("pre_rst", W'(o_valid), W'(1));
        async_rst();
        step('1, mkrow(16'h5000), 1'b0);
        chk("post_rst", out_s, mkrow(16'h5000));
        step('0, '0, 1'b1);
        chk("post_pop", W'(o_valid), W'(0));

        // random traffic
        for (int k = 0; k < 400; k++) begin
            logic [NC-1:0] w;
            w = ($urandom_range(0, 1) == 1) ? '1 : NC'($urandom);
            step(w, {$urandom, $urandom, $urandom, $urandom},
                 $urandom_range(0, 3) != 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
